i2c_target_tx: RTL and testbench
================================

I2C_TARGET_TX -- requirements
Module: i2c_target_tx

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h50: 7-bit address this target answers for reads.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on scl and sda_in.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 scl  input  1  bus clock from the master.
REQ-006 sda_in  input  1  resolved bus SDA level.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 tx_data  input  8  next byte to transmit.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  one-cycle pulse; tx_data is consumed this cycle.
REQ-011 busy  output  1  high from address match until STOP or return to IDLE.
REQ-012 byte_done  output  1  one-cycle pulse after the master's ACK/NACK bit is sampled.
REQ-013 master_nack  output  1  sticky; master NACKed the last byte; cleared on next START.
REQ-014 underrun  output  1  one-cycle pulse; a byte was needed while tx_valid was low.

Function
REQ-015 scl and sda_in SHALL pass through SYNC_STAGES flops; all edge detection SHALL use synchronized values.
REQ-016 START is defined as sda falling while scl is high; STOP is defined as sda rising while scl is high.
REQ-017 States SHALL be IDLE, ADDR, ADDR_ACK, TX_BIT, M_ACK, WAIT_STOP.
REQ-018 START in any state SHALL go to ADDR, clear the bit counter, and release sda_oe (repeated START included).
REQ-019 STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-020 ADDR SHALL shift sda MSB-first on each scl rising edge, 8 bits total: 7-bit address, then R/W.
REQ-021 On the 8th scl falling edge:
- address==TARGET_ADDR and R/W=1: assert sda_oe (ACK), set busy, enter ADDR_ACK.
- otherwise: release sda_oe and enter WAIT_STOP.
REQ-022 On the falling edge that ends the ACK bit, the block SHALL load the shift register:
- from tx_data with a tx_ready pulse if tx_valid=1;
- otherwise with 8'hFF and an underrun pulse.
REQ-023 In the same cycle as REQ-022, the block SHALL drive bit 7 (sda_oe = ~bit) and enter TX_BIT.
REQ-024 TX_BIT SHALL change sda_oe only in the cycle after a detected scl falling edge, never while scl is high.
REQ-025 After the 8th data-bit scl falling edge, the block SHALL release sda_oe and enter M_ACK.
REQ-026 M_ACK SHALL sample sda on the scl rising edge and pulse byte_done:
- sample 0 (ACK): at the next scl falling edge, load the next byte per REQ-022 and return to TX_BIT.
- sample 1 (NACK): set master_nack and enter WAIT_STOP with sda_oe=0.
REQ-027 WAIT_STOP SHALL keep sda_oe=0 and leave only on START or STOP.
REQ-028 A simultaneous START/STOP detection and an scl edge SHALL resolve in favour of START/STOP.
REQ-029 tx_ready SHALL never assert unless tx_valid is high in the same cycle.

Reset
REQ-030 While rst is high:
- state = IDLE;
- sda_oe, tx_ready, busy, byte_done, master_nack, underrun = 0;
- synchronizers preset to 1 (idle bus).
REQ-031 Deasserting rst mid-transfer SHALL leave the block in IDLE, ignoring bus activity until the next START.

Structure
REQ-032 The state enum and the START/STOP edge-detect constants SHALL live in a shared package, i2c_pkg, also used by the master and slave.
REQ-033 The synchronizer plus START/STOP/edge detector SHALL be one sub-module, i2c_bus_monitor, reusable by the receive slave.

Verification
REQ-034 Bench SHALL cover:
- Read of 0x50, tx_data=8'hA5 valid, master NACK -> ACK on bit 9; bits 1,0,1,0,0,1,0,1 on SDA; byte_done pulse; master_nack=1; busy drops on STOP.
- Read of 0x51 -> sda_oe stays 0 throughout; busy=0.
- Write to 0x50 (R/W=0) -> no ACK; state WAIT_STOP.
- Two-byte read 8'h3C then 8'hC3, master ACK then NACK -> two tx_ready pulses; both bytes correct on SDA.
- tx_valid low at byte load -> underrun pulse; 8'hFF transmitted.
- Repeated START mid-byte, then read 0x50 -> clean re-address and ACK.
- rst asserted mid-byte -> sda_oe=0 within one clk edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and SDA edge patterns for START/STOP detection.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX_BIT,
    M_ACK,
    WAIT_STOP
  } i2c_state_e;

  // {previous, current} synchronized SDA levels; START is a fall, STOP a rise, both with SCL high.
  localparam logic [1:0] SDA_FALL_PAT = 2'b10;
  localparam logic [1:0] SDA_RISE_PAT = 2'b01;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_cur;
  logic                   sda_cur;

  // Everything presets high so a reset looks like an idle bus and produces no spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_cur;
      sda_prev_q <= sda_cur;
    end
  end

  assign scl_cur    = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur    = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_cur;
  assign scl_rise_o = ~scl_prev_q & scl_cur;
  assign scl_fall_o = scl_prev_q & ~scl_cur;
  assign start_o    = scl_prev_q & scl_cur & ({sda_prev_q, sda_cur} == SDA_FALL_PAT);
  assign stop_o     = scl_prev_q & scl_cur & ({sda_prev_q, sda_cur} == SDA_RISE_PAT);

endmodule

// File: rtl/i2c_target_tx.sv
// I2C read-only target: answers reads at TARGET_ADDR and shifts tx_data bytes out MSB-first.
module i2c_target_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       byte_done,
  output logic       master_nack,
  output logic       underrun
);

  i2c_state_e state_q;
  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       byte_done_q;
  logic       nack_q;
  logic       underrun_q;
  logic       acked_q;

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       load_byte;
  logic [7:0] load_val;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_monitor (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  // A byte is fetched on the falling edge closing our address ACK or a master ACK.
  assign load_byte = ~start_det & ~stop_det & scl_fall &
                     ((state_q == ADDR_ACK) | ((state_q == M_ACK) & acked_q));
  assign load_val  = tx_valid ? tx_data : 8'hFF;
  assign tx_ready  = load_byte & tx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      nack_q      <= 1'b0;
      underrun_q  <= 1'b0;
      acked_q     <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        nack_q    <= 1'b0;
        acked_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (load_byte) begin
        shift_q    <= load_val;
        sda_oe_q   <= ~load_val[7];
        underrun_q <= ~tx_valid;
        bit_cnt_q  <= '0;
        acked_q    <= 1'b0;
        state_q    <= TX_BIT;
      end else begin
        case (state_q)
          IDLE: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
          ADDR: begin
            if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
              if (shift_q[7:1] == TARGET_ADDR && shift_q[0]) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= ADDR_ACK;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: sda_oe_q <= 1'b1;
          TX_BIT: begin
            // Data only moves after SCL falls, so SDA is stable for the whole high phase.
            if (scl_fall) begin
              if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                sda_oe_q <= 1'b0;
                state_q  <= M_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          M_ACK: begin
            if (scl_rise) begin
              byte_done_q <= 1'b1;
              if (sda_s) begin
                nack_q   <= 1'b1;
                sda_oe_q <= 1'b0;
                state_q  <= WAIT_STOP;
              end else begin
                acked_q <= 1'b1;
              end
            end
          end
          WAIT_STOP: sda_oe_q <= 1'b0;
          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign byte_done   = byte_done_q;
  assign master_nack = nack_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2c_target_tx.sv
// Directed bench for i2c_target_tx: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_target_tx;
  import i2c_pkg::*;

  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sda_oe;
  logic       tx_ready;
  logic       busy;
  logic       byte_done;
  logic       master_nack;
  logic       underrun;
  logic       sda_bus;

  int checks = 0;
  int failures = 0;
  int glitchCnt = 0;
  int readyCnt = 0;
  int doneCnt = 0;
  int underCnt = 0;
  int oeHighCnt = 0;
  int readyViol = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_tx #(
    .TARGET_ADDR(7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .byte_done  (byte_done),
    .master_nack(master_nack),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Pulse counters; tests take deltas across a transaction.
  always @(posedge clk) begin
    if (tx_ready) readyCnt <= readyCnt + 1;
    if (byte_done) doneCnt <= doneCnt + 1;
    if (underrun) underCnt <= underCnt + 1;
    if (sda_oe) oeHighCnt <= oeHighCnt + 1;
    if (tx_ready && !tx_valid) readyViol <= readyViol + 1;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    sda_m = 1'b1; waitClk(T);
    scl_m = 1'b1; waitClk(T);
    sda_m = 1'b0; waitClk(T);
    scl_m = 1'b0; waitClk(T);
  endtask

  task automatic busStop();
    sda_m = 1'b0; waitClk(T);
    scl_m = 1'b1; waitClk(T);
    sda_m = 1'b1; waitClk(T);
  endtask

  task automatic writeBit(input logic b);
    sda_m = b;    waitClk(T);
    scl_m = 1'b1; waitClk(T);
    scl_m = 1'b0; waitClk(T);
  endtask

  task automatic writeByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) writeBit(v[i]);
  endtask

  // SDA is sampled mid-high and again just before SCL falls; a change means it moved under SCL high.
  task automatic readBit(output logic b);
    sda_m = 1'b1; waitClk(T);
    scl_m = 1'b1; waitClk(T / 2);
    b = sda_bus;  waitClk(T / 2);
    if (sda_bus !== b) glitchCnt++;
    scl_m = 1'b0; waitClk(T);
  endtask

  task automatic readByte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      v[i] = b;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addrByte);
    busStart();
    writeByte(addrByte);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitClk(3);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (byte_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_done: got %b want 0", byte_done); end
    checks++; if (master_nack !== 1'b0) begin failures++; $display("[TB] FAIL reset_master_nack: got %b want 0", master_nack); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    rst = 1'b0;
    waitClk(5);
  endtask

  task automatic test_read_nack();
    logic       ack;
    logic [7:0] v;
    int r0, d0, u0;
    r0 = readyCnt; d0 = doneCnt; u0 = underCnt;
    tx_data = 8'hA5; tx_valid = 1'b1;
    applyStimulus(8'hA1);
    readBit(ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL a5_addr_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL a5_busy: got %b want 1", busy); end
    readByte(v);
    checks++; if (v !== 8'hA5) begin failures++; $display("[TB] FAIL a5_data: got %h want a5", v); end
    writeBit(1'b1);
    tx_valid = 1'b0;
    checks++; if (doneCnt - d0 !== 1) begin failures++; $display("[TB] FAIL a5_byte_done: got %0d want 1", doneCnt - d0); end
    checks++; if (readyCnt - r0 !== 1) begin failures++; $display("[TB] FAIL a5_tx_ready: got %0d want 1", readyCnt - r0); end
    checks++; if (underCnt - u0 !== 0) begin failures++; $display("[TB] FAIL a5_underrun: got %0d want 0", underCnt - u0); end
    checks++; if (master_nack !== 1'b1) begin failures++; $display("[TB] FAIL a5_master_nack: got %b want 1", master_nack); end
    busStop();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL a5_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic       ack;
    logic [7:0] v;
    int o0;
    o0 = oeHighCnt;
    applyStimulus(8'hA3);
    checks++; if (master_nack !== 1'b0) begin failures++; $display("[TB] FAIL nack_cleared_on_start: got %b want 0", master_nack); end
    readBit(ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL a51_no_ack: got %b want 1", ack); end
    readByte(v);
    checks++; if (oeHighCnt - o0 !== 0) begin failures++; $display("[TB] FAIL a51_sda_oe_cycles: got %0d want 0", oeHighCnt - o0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL a51_busy: got %b want 0", busy); end
    busStop();
  endtask

  task automatic test_write_addr();
    logic ack;
    applyStimulus(8'hA0);
    readBit(ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL write_no_ack: got %b want 1", ack); end
    checks++; if (dut.state_q !== WAIT_STOP) begin failures++; $display("[TB] FAIL write_state: got %0d want %0d", dut.state_q, WAIT_STOP); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL write_busy: got %b want 0", busy); end
    busStop();
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL write_stop_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_back_to_back();
    logic       ack;
    logic [7:0] v1, v2;
    int r0, d0;
    r0 = readyCnt; d0 = doneCnt;
    tx_data = 8'h3C; tx_valid = 1'b1;
    applyStimulus(8'hA1);
    readBit(ack);
    readByte(v1);
    tx_data = 8'hC3;
    writeBit(1'b0);
    readByte(v2);
    writeBit(1'b1);
    tx_valid = 1'b0;
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL b2b_addr_ack: got %b want 0", ack); end
    checks++; if (v1 !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_byte0: got %h want 3c", v1); end
    checks++; if (v2 !== 8'hC3) begin failures++; $display("[TB] FAIL b2b_byte1: got %h want c3", v2); end
    checks++; if (readyCnt - r0 !== 2) begin failures++; $display("[TB] FAIL b2b_tx_ready: got %0d want 2", readyCnt - r0); end
    checks++; if (doneCnt - d0 !== 2) begin failures++; $display("[TB] FAIL b2b_byte_done: got %0d want 2", doneCnt - d0); end
    checks++; if (master_nack !== 1'b1) begin failures++; $display("[TB] FAIL b2b_master_nack: got %b want 1", master_nack); end
    busStop();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_underrun();
    logic       ack;
    logic [7:0] v;
    int r0, u0;
    r0 = readyCnt; u0 = underCnt;
    tx_valid = 1'b0; tx_data = 8'h00;
    applyStimulus(8'hA1);
    readBit(ack);
    readByte(v);
    writeBit(1'b1);
    checks++; if (v !== 8'hFF) begin failures++; $display("[TB] FAIL underrun_data: got %h want ff", v); end
    checks++; if (underCnt - u0 !== 1) begin failures++; $display("[TB] FAIL underrun_pulse: got %0d want 1", underCnt - u0); end
    checks++; if (readyCnt - r0 !== 0) begin failures++; $display("[TB] FAIL underrun_tx_ready: got %0d want 0", readyCnt - r0); end
    busStop();
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] v;
    tx_data = 8'h5A; tx_valid = 1'b1;
    busStart();
    writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b0);
    applyStimulus(8'hA1);
    readBit(ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rstart_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstart_busy: got %b want 1", busy); end
    readByte(v);
    writeBit(1'b1);
    tx_valid = 1'b0;
    checks++; if (v !== 8'h5A) begin failures++; $display("[TB] FAIL rstart_data: got %h want 5a", v); end
    busStop();
  endtask

  task automatic test_reset_mid_byte();
    logic ack, b;
    int o0;
    tx_data = 8'h3C; tx_valid = 1'b1;
    applyStimulus(8'hA1);
    readBit(ack);
    readBit(b);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("[TB] FAIL midbyte_driving: got %b want 1", sda_oe); end
    rst = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL midbyte_reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midbyte_reset_busy: got %b want 0", busy); end
    waitClk(2);
    rst = 1'b0;
    tx_valid = 1'b0;
    o0 = oeHighCnt;
    readBit(b); readBit(b); readBit(b);
    checks++; if (oeHighCnt - o0 !== 0) begin failures++; $display("[TB] FAIL after_reset_sda_oe_cycles: got %0d want 0", oeHighCnt - o0); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL after_reset_state: got %0d want %0d", dut.state_q, IDLE); end
    busStop();
  endtask

  initial begin
    test_reset();
    test_read_nack();
    test_wrong_addr();
    test_write_addr();
    test_back_to_back();
    test_underrun();
    test_repeated_start();
    test_reset_mid_byte();
    checks++; if (readyViol !== 0) begin failures++; $display("[TB] FAIL tx_ready_without_valid: got %0d want 0", readyViol); end
    checks++; if (glitchCnt !== 0) begin failures++; $display("[TB] FAIL sda_change_scl_high: got %0d want 0", glitchCnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
